// File: rtl/cpu_pkg.sv
// cpu_pkg: fetch state encoding and instruction constants shared by the fetch path
package cpu_pkg;
  typedef enum logic [1:0] {FETCH, HALT_PEND, HALTED} state_t;
  localparam logic [10:0] HALT_OPCODE = 11'h7FF;
  localparam logic [31:0] NOP = 32'hD503201F;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: flushable circular queue; a push while full is taken only alongside a pop
module fetch_fifo #(
  parameter int W = 32,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         push,
  input  logic [W-1:0]                 wdata,
  input  logic                         pop,
  output logic [W-1:0]                 rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata = mem[rd];
  always_ff @(posedge clk)
    if (do_push) mem[wr] <= wdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else if (flush) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else begin
      wr <= wr + AW'(do_push);
      rd <= rd + AW'(do_pop);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: credit-limited in-order instruction prefetcher with redirect and HALT handling
// Optional FETCH_STATS_EN adds saturating fetch_count/flush_count outputs.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int              PC_W     = 64,
  parameter int              INSTR_W  = 32,
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [PC_W-1:0]    imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_data,
  output logic [PC_W-1:0]    instr_pc,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               halted
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]        fetch_count,
  output logic [15:0]        flush_count
`endif
);
  localparam int CW = $clog2(DEPTH+1);
  state_t state;
  logic run, fire, push, pop, halt_push, full, empty;
  logic [PC_W-1:0] pc, push_pc;
  logic [CW-1:0] outstanding, discard, count;
  logic [PC_W+INSTR_W-1:0] head;
  logic unused_ok;
  assign unused_ok = ^{redirect_pc[1:0], full};
  assign imem_req_valid = run && state == FETCH && !redirect_valid &&
                          ({1'b0, outstanding} + {1'b0, count}) < (CW+1)'(DEPTH);
  assign imem_req_addr = pc;
  assign fire = imem_req_valid && imem_req_ready;
  assign push = imem_rsp_valid && discard == '0 && state == FETCH && !redirect_valid;
  assign pop = instr_valid && instr_ready && !redirect_valid;
  assign halt_push = push && imem_rsp_data[31:21] == HALT_OPCODE;
  // with nothing left to discard, every in-flight request is sequential from pc
  assign push_pc = pc - (PC_W'(outstanding) << 2);
  assign instr_valid = !empty;
  assign {instr_pc, instr_data} = empty ? '0 : head;
  assign halted = state == HALTED;
  fetch_fifo #(.W(PC_W + INSTR_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .flush(redirect_valid),
    .push(push),
    .wdata({push_pc, imem_rsp_data}),
    .pop(pop),
    .rdata(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= FETCH;
      run <= 1'b0;
      pc <= RESET_PC;
      outstanding <= '0;
      discard <= '0;
    end else begin
      run <= 1'b1;
      outstanding <= outstanding + CW'(fire) - CW'(imem_rsp_valid);
      if (redirect_valid) begin
        state <= FETCH;
        pc <= {redirect_pc[PC_W-1:2], 2'b00};
        discard <= outstanding - CW'(imem_rsp_valid);
      end else begin
        if (fire) pc <= pc + PC_W'(4);
        if (imem_rsp_valid && discard != '0) discard <= discard - CW'(1);
        if (halt_push) state <= HALT_PEND;
        else if (state == HALT_PEND && pop && instr_data[31:21] == HALT_OPCODE) state <= HALTED;
      end
    end
`ifdef FETCH_STATS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fetch_count <= '0;
      flush_count <= '0;
    end else begin
      if (pop && ~&fetch_count) fetch_count <= fetch_count + 32'd1;
      if (redirect_valid && ~&flush_count) flush_count <= flush_count + 16'd1;
    end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: random and directed stimulus against an epoch-tagged request/instruction queue model
module tb_fetch_unit;
  localparam int DEPTH = 4;
  localparam logic [63:0] NO_HALT = 64'hDEAD_0000_0000_0000;
  typedef struct {logic [63:0] addr; int ep; int avail;} req_t;
  typedef struct {logic [63:0] pc; logic [31:0] data;} ins_t;

  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;

  logic        imem_req_valid, imem_req_ready, imem_rsp_valid, instr_valid, instr_ready;
  logic        redirect_valid, halted;
  logic [63:0] imem_req_addr, instr_pc, redirect_pc;
  logic [31:0] imem_rsp_data, instr_data;
  logic        v8, iv8, h8, r8;
  logic [7:0]  addr8, ipc8;
  logic [31:0] idata8;
`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count, fc8;
  logic [15:0] flush_count, flc8;
`endif

  fetch_unit #(.PC_W(64), .INSTR_W(32), .DEPTH(DEPTH), .RESET_PC(64'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data), .instr_pc(instr_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halted(halted)
`ifdef FETCH_STATS_EN
    , .fetch_count(fetch_count), .flush_count(flush_count)
`endif
  );

  fetch_unit #(.PC_W(8), .INSTR_W(32), .DEPTH(DEPTH), .RESET_PC(8'hFC)) u8 (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(v8), .imem_req_ready(1'b1), .imem_req_addr(addr8),
    .imem_rsp_valid(r8), .imem_rsp_data(32'hD503201F),
    .instr_valid(iv8), .instr_ready(1'b1), .instr_data(idata8), .instr_pc(ipc8),
    .redirect_valid(1'b0), .redirect_pc(8'h00), .halted(h8)
`ifdef FETCH_STATS_EN
    , .fetch_count(fc8), .flush_count(flc8)
`endif
  );

  // single-cycle memory for the narrow-PC instance
  always @(posedge clk or negedge rst_n)
    if (!rst_n) r8 <= 1'b0;
    else r8 <= v8;
  logic [7:0] a8[$];
  always @(negedge clk)
    if (rst_n && v8 && a8.size() < 3) a8.push_back(addr8);

  int n_chk = 0, n_pass = 0;
  int cyc = 0, rel_cyc = 0;
  int p_ready, p_rsp, p_iready, p_redir;
  bit use_nop, started, redir_once, rsp_this;
  logic [63:0] redir_once_pc, halt_addr = NO_HALT;
  req_t mq[$];
  ins_t dq[$];
  req_t cur;
  int epoch = 0, mstate = 0, m_pops = 0, m_flush = 0;
  logic [63:0] exp_req_pc;
  int n_fire, n_pop, valid_cyc, pop8_cyc, halt_cyc;
  bit arm_fire, arm_valid, halt_seen;
  logic [63:0] fire_addr, valid_pc, fq[$];
  logic [31:0] valid_data;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    else n_pass++;
  endtask

  function automatic logic [31:0] word(logic [63:0] a);
    if (a == halt_addr) return 32'hFFE00000;
    if (use_nop) return 32'hD503201F;
    return {8'h12, a[23:0]};
  endfunction

  task automatic drive();
    imem_req_ready = $urandom_range(0, 99) < p_ready;
    instr_ready = $urandom_range(0, 99) < p_iready;
    if (redir_once) begin
      redirect_valid = 1'b1;
      redirect_pc = redir_once_pc;
      redir_once = 0;
    end else begin
      redirect_valid = $urandom_range(0, 99) < p_redir;
      redirect_pc = ($urandom_range(0, 9) == 0) ? 64'hFFFF_FFFF_FFFF_FFF5 : 64'($urandom_range(0, 511));
    end
    rsp_this = 0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = $urandom;
    if (mq.size() != 0 && mq[0].avail <= cyc && $urandom_range(0, 99) < p_rsp) begin
      cur = mq.pop_front();
      rsp_this = 1;
      imem_rsp_valid = 1'b1;
      imem_rsp_data = word(cur.addr);
    end
  endtask

  task automatic check_update();
    bit rv, red;
    ins_t h;
    logic [31:0] w;
    red = redirect_valid;
    rv = started && mstate == 0 && !red && (mq.size() + int'(rsp_this) + dq.size() < DEPTH);
    chk("instr_valid", instr_valid, dq.size() != 0);
    if (dq.size() != 0) begin
      chk("instr_pc", instr_pc, dq[0].pc);
      chk("instr_data", instr_data, dq[0].data);
    end
    chk("halted", halted, mstate == 2);
    chk("req_valid", imem_req_valid, rv);
    if (rv) chk("req_addr", imem_req_addr, exp_req_pc);
`ifdef FETCH_STATS_EN
    chk("fetch_count", fetch_count, m_pops);
    chk("flush_count", flush_count, m_flush);
`endif
    if (imem_req_valid && imem_req_ready) begin
      n_fire++;
      if (fq.size() < 8) fq.push_back(imem_req_addr);
      if (arm_fire) begin fire_addr = imem_req_addr; arm_fire = 0; end
    end
    if (arm_valid && instr_valid) begin
      valid_cyc = cyc - rel_cyc;
      valid_pc = instr_pc;
      valid_data = instr_data;
      arm_valid = 0;
    end
    if (instr_valid && instr_ready && !red) begin
      n_pop++;
      if (instr_pc == 64'h8) pop8_cyc = cyc;
    end
    if (halted && !halt_seen) begin halt_seen = 1; halt_cyc = cyc; end
    if (rv && imem_req_ready) begin
      mq.push_back('{exp_req_pc, epoch, cyc + 1});
      exp_req_pc += 64'd4;
    end
    if (red) begin
      epoch++;
      dq.delete();
      mstate = 0;
      exp_req_pc = {redirect_pc[63:2], 2'b00};
      if (m_flush < 65535) m_flush++;
    end else begin
      if (dq.size() != 0 && instr_ready) begin
        h = dq.pop_front();
        m_pops++;
        if (mstate == 1 && h.data[31:21] == 11'h7FF) mstate = 2;
      end
      if (rsp_this && cur.ep == epoch && mstate == 0) begin
        w = word(cur.addr);
        dq.push_back('{cur.addr, w});
        if (w[31:21] == 11'h7FF) mstate = 1;
      end
    end
  endtask

  task automatic step(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      cyc++;
      started = 1;
      #1;
      drive();
      @(negedge clk);
      check_update();
    end
  endtask

  task automatic idle_inputs();
    imem_req_ready = 0; instr_ready = 0; redirect_valid = 0; redirect_pc = '0;
    imem_rsp_valid = 0; imem_rsp_data = '0; rsp_this = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle_inputs();
    mq.delete(); dq.delete(); fq.delete();
    mstate = 0; exp_req_pc = 64'h0; m_pops = 0; m_flush = 0;
    n_fire = 0; n_pop = 0; arm_fire = 0; arm_valid = 0; halt_seen = 0; redir_once = 0;
    valid_cyc = -1; pop8_cyc = -1; halt_cyc = -1; fire_addr = '1; valid_pc = '1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_req_valid", imem_req_valid, 0);
      chk("rst_req_addr", imem_req_addr, 64'h0);
      chk("rst_instr_valid", instr_valid, 0);
      chk("rst_instr_data", instr_data, 0);
      chk("rst_instr_pc", instr_pc, 0);
      chk("rst_halted", halted, 0);
    end
    @(posedge clk);
    cyc++;
    #1;
    rst_n = 1;
    rel_cyc = cyc;
    started = 0;
    @(negedge clk);
    check_update();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    p_ready = 100; p_rsp = 100; p_iready = 100; p_redir = 0;
    // sequential NOP stream with 1-cycle memory
    use_nop = 1;
    @(negedge clk);
    do_reset();
    arm_valid = 1;
    step(8);
    chk("first_valid_cycle", valid_cyc, 3);
    chk("first_valid_pc", valid_pc, 64'h0);
    chk("first_valid_data", valid_data, 32'hD503201F);
    chk("req_seq_len", fq.size() >= 3, 1);
    if (fq.size() >= 3) begin
      chk("req_seq0", fq[0], 64'h0);
      chk("req_seq1", fq[1], 64'h4);
      chk("req_seq2", fq[2], 64'h8);
    end
    chk("pc8_seq_len", a8.size(), 3);
    if (a8.size() == 3) begin
      chk("pc8_seq0", a8[0], 8'hFC);
      chk("pc8_seq1", a8[1], 8'h00);
      chk("pc8_seq2", a8[2], 8'h04);
    end
    use_nop = 0;
    // consumer stalled: credit caps issue at DEPTH
    p_iready = 0;
    do_reset();
    step(12);
    chk("fill_fires", n_fire, 4);
    chk("fill_stall", imem_req_valid, 0);
    p_iready = 100;
    step(1);
    p_iready = 0;
    step(3);
    chk("refill_fires", n_fire, 5);
    // redirect with two requests in flight
    p_iready = 100; p_rsp = 0;
    do_reset();
    for (int i = 0; i < 10 && n_fire < 2; i++) step(1);
    chk("redir_setup_fires", n_fire, 2);
    p_ready = 0;
    redir_once = 1; redir_once_pc = 64'h103;
    arm_fire = 1; arm_valid = 1;
    step(1);
    p_ready = 100; p_rsp = 100;
    step(8);
    chk("redir_req_addr", fire_addr, 64'h100);
    chk("redir_instr_pc", valid_pc, 64'h100);
    chk("redir_instr_data", valid_data, 32'h12000100);
    // HALT at 0x8
    halt_addr = 64'h8;
    do_reset();
    step(15);
    chk("halt_fires", n_fire, 4);
    chk("halt_high", halted, 1);
    chk("halt_after_pop", halt_cyc - pop8_cyc, 1);
    halt_addr = NO_HALT;
    redir_once = 1; redir_once_pc = 64'h0;
    step(2);
    chk("halt_cleared", halted, 0);
    step(6);
`ifdef FETCH_STATS_EN
    p_iready = 0;
    do_reset();
    step(10);
    p_iready = 100;
    for (int i = 0; i < 20 && n_pop < 5; i++) step(1);
    p_iready = 0;
    chk("stats_pops", n_pop, 5);
    redir_once = 1; redir_once_pc = 64'h0;
    step(3);
    redir_once = 1; redir_once_pc = 64'h40;
    step(3);
    chk("stats_fetch_count", fetch_count, 32'd5);
    chk("stats_flush_count", flush_count, 16'd2);
`endif
    // randomized traffic
    do_reset();
    for (int s = 0; s < 30; s++) begin
      p_ready = $urandom_range(30, 100);
      p_rsp = $urandom_range(30, 100);
      p_iready = $urandom_range(20, 100);
      p_redir = $urandom_range(0, 5);
      halt_addr = ($urandom_range(0, 2) == 0) ? 64'h20 + 64'(4 * $urandom_range(0, 15)) : NO_HALT;
      if (s == 15) do_reset();
      step(100);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
